// File: rtl/mac_accumulator.sv
// mac_accumulator
//   Sums groups of N unsigned 8-bit products into an ACC_W-bit result.
//   A two-state controller alternates between collecting products (ACCUM)
//   and presenting the finished sum (DONE) until downstream takes it.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   p         : unsigned product from the upstream multiplier
//   p_valid   : p is valid this cycle
//   p_ready   : block accepts p this cycle (registered, high in ACCUM)
//   clear     : drop the partial sum in progress (ignored in DONE)
//   res       : registered sum of the last completed group
//   res_valid : res is valid (registered, high in DONE)
//   res_ready : downstream takes res this cycle
//   ovf       : sticky carry-out flag for the group being summed / in res
//   cnt       : number of products accepted in the current group
module mac_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             p,
  input  logic                   p_valid,
  output logic                   p_ready,
  input  logic                   clear,
  output logic [ACC_W-1:0]       res,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   ovf,
  output logic [$clog2(N)-1:0]   cnt
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum_ext;

  // Modulo-2^ACC_W add of a zero-extended product; the top bit is the carry.
  function automatic logic [ACC_W:0] add_carry(input logic [ACC_W-1:0] a,
                                               input logic [7:0]       b);
    return {1'b0, a} + {{(ACC_W - 7){1'b0}}, b};
  endfunction

  assign sum_ext = add_carry(acc, p);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      res       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      p_ready   <= 1'b1;
      res_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (clear) begin
            // clear wins over a product offered in the same cycle
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
          end else if (p_valid && p_ready) begin
            ovf <= ovf | sum_ext[ACC_W];
            if (cnt == LAST) begin
              // final product: result goes straight into res, acc restarts
              res       <= sum_ext[ACC_W-1:0];
              acc       <= '0;
              cnt       <= '0;
              state     <= DONE;
              p_ready   <= 1'b0;
              res_valid <= 1'b1;
            end else begin
              acc <= sum_ext[ACC_W-1:0];
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          // res/ovf are held here; clear and p are ignored
          if (res_ready) begin
            state     <= ACCUM;
            acc       <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            p_ready   <= 1'b1;
            res_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator. Two instances (ACC_W=10 and ACC_W=8)
// receive identical stimulus; expected results are queued by the stimulus
// process and checked by an independent monitor whenever res_valid is high.
module tb_mac_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] p = '0;
  logic       p_valid = 1'b0;
  logic       clear = 1'b0;
  logic       res_ready = 1'b1;

  logic       p_ready, res_valid, ovf;
  logic [9:0] res;
  logic [1:0] cnt;
  logic       p_ready8, res_valid8, ovf8;
  logic [7:0] res8;
  logic [1:0] cnt8;

  always #5 clk = ~clk;

  mac_accumulator #(.N(4), .ACC_W(10)) dut (
    .clk(clk), .rst(rst), .p(p), .p_valid(p_valid), .p_ready(p_ready),
    .clear(clear), .res(res), .res_valid(res_valid), .res_ready(res_ready),
    .ovf(ovf), .cnt(cnt)
  );

  mac_accumulator #(.N(4), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .p(p), .p_valid(p_valid), .p_ready(p_ready8),
    .clear(clear), .res(res8), .res_valid(res_valid8), .res_ready(res_ready),
    .ovf(ovf8), .cnt(cnt8)
  );

  typedef struct {
    int r10;
    int o10;
    int r8;
    int o8;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   rand_ready = 1'b0;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  task automatic push_exp(input int r10, input int o10, input int r8, input int o8);
    exp_t e;
    e.r10 = r10; e.o10 = o10; e.r8 = r8; e.o8 = o8;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    p_valid = 1'b0;
    repeat (n) begin
      if (rand_ready) res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
  endtask

  // Offer one product and wait (bounded) until it is accepted.
  task automatic send(input int v);
    bit done;
    done = 1'b0;
    p = v[7:0];
    p_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      bit taken;
      taken = p_ready;
      if (rand_ready) res_ready = ($urandom_range(0, 3) != 0);
      step();
      if (taken) done = 1'b1;
    end
    p_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: product %0d not accepted, p_ready=%0d", v, p_ready);
    end
  endtask

  // Monitor: compares every presented result against the queue head,
  // pops on handshake.
  always @(negedge clk) begin
    if (!rst && (res_valid || res_valid8)) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL mon_unexpected: res_valid with res=%0d, expected no result", res);
      end else begin
        chk("mon_res",   res,        q[0].r10);
        chk("mon_ovf",   ovf,        q[0].o10);
        chk("mon_res8",  res8,       q[0].r8);
        chk("mon_ovf8",  ovf8,       q[0].o8);
        chk("mon_vld8",  res_valid8, res_valid);
        if (res_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    int sum;
    int v;

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk("rst_p_ready", p_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ovf", ovf, 0);

    // Basic group: 12+34+56+78 = 180
    push_exp(180, 0, 180, 0);
    send(12); send(34); send(56);
    chk("basic_cnt3", cnt, 3);
    chk("basic_no_vld", res_valid, 0);
    send(78);
    chk("basic_latency_vld", res_valid, 1);
    chk("basic_res", res, 180);
    chk("basic_p_ready_done", p_ready, 0);
    step();
    chk("basic_one_cycle", res_valid, 0);
    chk("basic_back_accum", p_ready, 1);

    // Maximum products with backpressure: 4*225 = 900; 900 mod 256 = 132
    res_ready = 1'b0;
    push_exp(900, 0, 132, 1);
    send(225); send(225); send(225); send(225);
    chk("max_res", res, 900);
    chk("max_res8", res8, 132);
    chk("max_ovf8", ovf8, 1);
    for (int i = 0; i < 5; i++) begin
      p = 8'd99;
      p_valid = (i % 2 == 0);
      clear = 1'b1;
      step();
      chk("bp_p_ready", p_ready, 0);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_hold", res, 900);
    end
    p_valid = 1'b0;
    clear = 1'b0;
    res_ready = 1'b1;
    step();
    chk("bp_release_vld", res_valid, 0);
    chk("bp_release_cnt", cnt, 0);
    chk("bp_release_ovf8", ovf8, 0);
    push_exp(4, 0, 4, 0);
    send(1); send(1); send(1); send(1);
    step();

    // Clear discards partial sum and the product offered alongside it
    push_exp(10, 0, 10, 0);
    send(100); send(50);
    p = 8'd7;
    p_valid = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    p_valid = 1'b0;
    chk("clear_cnt", cnt, 0);
    chk("clear_ovf8", ovf8, 0);
    send(1); send(2); send(3); send(4);
    step();

    // Reset mid-group
    send(3); send(3); send(3);
    chk("mid_cnt3", cnt, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_vld", res_valid, 0);
    chk("mid_rst_res", res, 0);
    chk("mid_rst_p_ready", p_ready, 1);

    // Reset while a result is pending drops it
    res_ready = 1'b0;
    push_exp(20, 0, 20, 0);
    send(5); send(5); send(5); send(5);
    chk("done_vld", res_valid, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(q.pop_front());
    chk("done_rst_vld", res_valid, 0);
    chk("done_rst_res", res, 0);
    chk("done_rst_res8", res8, 0);
    chk("done_rst_p_ready", p_ready, 1);
    res_ready = 1'b1;
    push_exp(36, 0, 36, 0);
    send(9);
    chk("post_rst_cnt1", cnt, 1);
    send(9); send(9); send(9);
    step();

    // Random gaps and random downstream readiness over 1000 groups
    rand_ready = 1'b1;
    for (int g = 0; g < 1000; g++) begin
      sum = 0;
      for (int k = 0; k < 4; k++) begin
        idle($urandom_range(0, 2));
        v = $urandom_range(0, 255);
        sum += v;
        if (k == 3) push_exp(sum % 1024, (sum >= 1024) ? 1 : 0, sum % 256, (sum >= 256) ? 1 : 0);
        send(v);
      end
    end
    rand_ready = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk("drain_queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
